// File: rtl/store_narrow_buffer_pkg.sv
// store_narrow_buffer_pkg: shared store-path definitions.
// Size encodings, the queued entry layout {addr[31:2], wdata, be} and the
// narrowing/alignment helpers used when a store is accepted.
package store_narrow_buffer_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // One queued store: word address, lane-aligned data, byte enables.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  localparam int EB_W = $bits(entry_t);  // 66

  // Replicate the narrowed value into every lane it could occupy and let the
  // byte enables pick the lane(s) that memory actually writes.
  function automatic entry_t align_store(input logic [31:0] addr,
                                         input logic [31:0] data,
                                         input logic [1:0]  size);
    entry_t e;
    e.addr = addr[31:2];
    case (size_e'(size))
      SZ_BYTE: begin
        e.wdata = {4{data[7:0]}};
        e.be    = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        e.wdata = {2{data[15:0]}};
        e.be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin  // word and reserved encoding behave identically
        e.wdata = data;
        e.be    = 4'b1111;
      end
    endcase
    return e;
  endfunction

  // A half must sit on an even byte, a word (or reserved) on a word boundary.
  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [1:0] size);
    logic bad;
    case (size_e'(size))
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_narrow_buffer_if.sv
// store_narrow_buffer_if: request (from execute) and memory write-port
// handshakes of the store buffer. The buffer is the slave; the CPU/memory
// environment is the master.
interface store_narrow_buffer_if;
  import store_narrow_buffer_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_narrow_buffer_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and a head output
// taken straight from the storage registers (no write-to-read bypass).
// Pushes while full and pops while empty are ignored. Storage is reset so
// the head reads as zero out of reset.
module sync_fifo
  import store_narrow_buffer_pkg::*;
#(
  parameter int WIDTH = EB_W,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic [PW:0]      count_next;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + (PW+1)'(1);
      2'b01:   count_next = count_reg - (PW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally at DEPTH (power of two) and count tracks occupancy.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Each slot captures the incoming entry when it is the write target.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
          mem_reg[gi] <= '0;
        end else if (push_ok && (wr_ptr_reg == PW'(gi))) begin
          mem_reg[gi] <= din;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows a register value to byte/half/word, lane-aligns
// it with byte enables and queues it for the data-memory write port.
// Memory-side outputs come only from the FIFO head register, so there is no
// combinational path from the request side to the memory side.
// Optional macro MISALIGN_CHECK_EN: misaligned half/word requests are
// acknowledged but dropped, and 'misaligned' pulses for the following cycle.
module store_narrow_buffer
  import store_narrow_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    Clk,
  input  logic                    Clrn,
  store_narrow_buffer_if.slave    bus,
  output logic                    empty,
  output logic                    misaligned
);

  entry_t            req_entry;
  entry_t            head_entry;
  logic [EB_W-1:0]   head_bits;
  logic              full;
  logic              accept;
  logic              bad_req;
  logic              push;
  logic              pop;

  assign req_entry = align_store(bus.req_addr, bus.req_data, bus.req_size);

  assign bus.req_ready = !full;
  assign accept        = bus.req_valid && !full;
  assign push          = accept && !bad_req;
  assign pop           = bus.mem_valid && bus.mem_ready;

  sync_fifo #(
    .WIDTH (EB_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Clrn  (Clrn),
    .push  (push),
    .pop   (pop),
    .din   (req_entry),
    .full  (full),
    .empty (empty),
    .head  (head_bits)
  );

  assign head_entry    = entry_t'(head_bits);
  assign bus.mem_valid = !empty;
  assign bus.mem_addr  = {head_entry.addr, 2'b00};
  assign bus.mem_wdata = head_entry.wdata;
  assign bus.mem_be    = head_entry.be;

`ifdef MISALIGN_CHECK_EN
  logic misaligned_reg;

  assign bad_req    = is_misaligned(bus.req_addr[1:0], bus.req_size);
  assign misaligned = misaligned_reg;

  // Flag each acknowledged-but-dropped request for exactly the next cycle.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      misaligned_reg <= 1'b0;
    end else begin
      misaligned_reg <= accept && bad_req;
    end
  end
`else
  assign bad_req    = 1'b0;
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_store_narrow_buffer.sv
// tb_store_narrow_buffer: directed checks of the store narrowing buffer.
module tb_store_narrow_buffer;
  import store_narrow_buffer_pkg::*;

  logic Clk;
  logic Clrn;
  logic empty;
  logic misaligned;
  int   checks;
  int   failures;

  store_narrow_buffer_if bus ();

  store_narrow_buffer #(.DEPTH(4)) dut (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .bus        (bus),
    .empty      (empty),
    .misaligned (misaligned)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Presents one request for a single clock edge; caller ensures req_ready.
  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = s;
    bus.req_valid = 1'b1;
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    $display("push addr=%h data=%h size=%0d", a, d, s);
  endtask

  task automatic test_reset();
    Clrn          = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_1234;
    bus.req_data  = 32'hFFFF_FFFF;
    bus.req_size  = 2'b10;
    bus.mem_ready = 1'b1;
    #3;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready); end
    checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b want=0", bus.mem_valid); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", empty); end
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'h0) begin failures++;
      $display("FAIL reset_mem_bus got=%h/%h/%b want=0/0/0", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b want=0", misaligned); end
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (bus.mem_valid !== 1'b0 || empty !== 1'b1) begin failures++;
      $display("FAIL reset_held got valid=%b empty=%b want 0/1", bus.mem_valid, empty); end
    bus.req_valid = 1'b0;
    @(negedge Clk);
    Clrn = 1'b1;
    repeat (2) begin
      @(posedge Clk); #1;
      checks++; if (bus.mem_valid !== 1'b0 || empty !== 1'b1) begin failures++;
        $display("FAIL reset_release got valid=%b empty=%b want 0/1", bus.mem_valid, empty); end
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_byte();
    bus.mem_ready = 1'b1;
    push_store(32'h0000_1003, 32'h1234_56AB, SZ_BYTE);
    checks++; if (bus.mem_valid !== 1'b1) begin failures++; $display("FAIL byte_valid got=%b want=1", bus.mem_valid); end
    checks++; if (bus.mem_addr !== 32'h0000_1000) begin failures++; $display("FAIL byte_addr got=%h want=00001000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'hABAB_ABAB) begin failures++; $display("FAIL byte_wdata got=%h want=abababab", bus.mem_wdata); end
    checks++; if (bus.mem_be !== 4'b1000) begin failures++; $display("FAIL byte_be got=%b want=1000", bus.mem_be); end
    @(posedge Clk); #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL byte_drained got empty=%b want=1", empty); end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_half_word();
    bus.mem_ready = 1'b0;
    push_store(32'h0000_2002, 32'hFFFF_8001, SZ_HALF);
    push_store(32'h0000_2004, 32'hDEAD_BEEF, SZ_WORD);
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {32'h0000_2000, 32'h8001_8001, 4'b1100}) begin failures++;
      $display("FAIL half_head got=%h/%h/%b want=00002000/80018001/1100", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
    bus.mem_ready = 1'b1;
    @(posedge Clk); #1;
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {32'h0000_2004, 32'hDEAD_BEEF, 4'b1111}) begin failures++;
      $display("FAIL word_head got=%h/%h/%b want=00002004/deadbeef/1111", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
    @(posedge Clk); #1;
    checks++; if (empty !== 1'b1 || bus.mem_valid !== 1'b0) begin failures++;
      $display("FAIL half_word_drain got empty=%b valid=%b want 1/0", empty, bus.mem_valid); end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_full_drain();
    logic [67:0] exp_q [5];
    exp_q[0] = {32'h0000_4000, 32'h1111_1111, 4'b0001};
    exp_q[1] = {32'h0000_4000, 32'h2222_2222, 4'b0010};
    exp_q[2] = {32'h0000_4000, 32'h3333_3333, 4'b0100};
    exp_q[3] = {32'h0000_4000, 32'h4444_4444, 4'b1000};
    exp_q[4] = {32'h0000_5000, 32'h5555_5555, 4'b1111};
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_store(32'h0000_4000 + 32'(i), 32'h11 * 32'(i + 1), SZ_BYTE);
    end
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b want=0", bus.req_ready); end
    // Fifth store waits while full.
    bus.req_addr = 32'h0000_5000; bus.req_data = 32'h5555_5555; bus.req_size = SZ_WORD; bus.req_valid = 1'b1;
    @(posedge Clk); #1;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL full_hold_ready got=%b want=0", bus.req_ready); end
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== exp_q[0]) begin failures++;
      $display("FAIL full_hold_head got=%h/%h/%b want=%h", bus.mem_addr, bus.mem_wdata, bus.mem_be, exp_q[0]); end
    bus.mem_ready = 1'b1;
    @(posedge Clk); #1;  // pop only: full blocks the push this edge
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_pop got=%b want=1", bus.req_ready); end
    checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== exp_q[1]) begin failures++;
      $display("FAIL drain_1 got=%h/%h/%b want=%h", bus.mem_addr, bus.mem_wdata, bus.mem_be, exp_q[1]); end
    @(posedge Clk); #1;  // push and pop together
    bus.req_valid = 1'b0;
    $display("push addr=00005000 data=55555555 size=2");
    for (int i = 2; i < 5; i++) begin
      checks++; if (bus.mem_valid !== 1'b1 || {bus.mem_addr, bus.mem_wdata, bus.mem_be} !== exp_q[i]) begin failures++;
        $display("FAIL drain_%0d got v=%b %h/%h/%b want=%h", i, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_be, exp_q[i]); end
      @(posedge Clk); #1;
    end
    checks++; if (empty !== 1'b1 || bus.mem_valid !== 1'b0) begin failures++;
      $display("FAIL full_drain_end got empty=%b valid=%b want 1/0", empty, bus.mem_valid); end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_store(32'h0000_6000 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), SZ_WORD);
    end
    checks++; if (bus.mem_valid !== 1'b1) begin failures++; $display("FAIL pending_valid got=%b want=1", bus.mem_valid); end
    #2;
    Clrn = 1'b0;
    #1;
    checks++; if (bus.mem_valid !== 1'b0 || empty !== 1'b1) begin failures++;
      $display("FAIL async_reset got valid=%b empty=%b want 0/1", bus.mem_valid, empty); end
    checks++; if (bus.req_ready !== 1'b1 || bus.mem_be !== 4'b0000) begin failures++;
      $display("FAIL async_reset_state got ready=%b be=%b want 1/0000", bus.req_ready, bus.mem_be); end
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Clrn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL discarded_emitted cycle=%0d got valid=%b want=0", i, bus.mem_valid); end
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_misalign();
    bus.mem_ready = 1'b0;
`ifdef MISALIGN_CHECK_EN
    bus.req_addr = 32'h0000_3001; bus.req_data = 32'hCAFE_F00D; bus.req_size = SZ_WORD; bus.req_valid = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL mis_accept got=%b want=1", bus.req_ready); end
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    $display("push addr=00003001 data=cafef00d size=2 (misaligned)");
    checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b want=1", misaligned); end
    checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL mis_not_enqueued got=%b want=0", bus.mem_valid); end
    @(posedge Clk); #1;
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_pulse_end got=%b want=0", misaligned); end
    // Two bad halves back to back hold the flag high for two cycles.
    bus.req_addr = 32'h0000_3003; bus.req_data = 32'h0000_1234; bus.req_size = SZ_HALF; bus.req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk); #1;
      checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_b2b_%0d got=%b want=1", i, misaligned); end
    end
    bus.req_valid = 1'b0;
    @(posedge Clk); #1;
    checks++; if (misaligned !== 1'b0 || bus.mem_valid !== 1'b0) begin failures++;
      $display("FAIL mis_b2b_end got mis=%b valid=%b want 0/0", misaligned, bus.mem_valid); end
`else
    push_store(32'h0000_3001, 32'hCAFE_F00D, SZ_WORD);
    checks++; if ({bus.mem_valid, bus.mem_addr, bus.mem_be} !== {1'b1, 32'h0000_3000, 4'b1111}) begin failures++;
      $display("FAIL noalign_head got v=%b %h/%b want 1/00003000/1111", bus.mem_valid, bus.mem_addr, bus.mem_be); end
    checks++; if (bus.mem_wdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL noalign_wdata got=%h want=cafef00d", bus.mem_wdata); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL noalign_flag got=%b want=0", misaligned); end
    bus.mem_ready = 1'b1;
    @(posedge Clk); #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL noalign_drain got empty=%b want=1", empty); end
    bus.mem_ready = 1'b0;
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = '0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_byte();
    test_half_word();
    test_full_drain();
    test_reset_mid_drain();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
